// File: rtl/node_integrator.sv
// Per-node charge integrator: sums signed branch currents, integrates them into a
// clamped node voltage, and derives a hysteresis logic level and a settle flag.
module node_integrator #(
  parameter int W          = 16,
  parameter int N          = 4,
  parameter int CAP_SHIFT  = 1,
  parameter int VHI        = 16384,
  parameter int VLO        = -16384,
  parameter int INIT       = -16384,
  parameter int TH_HI      = 4096,
  parameter int TH_LO      = -4096,
  parameter int EPS        = 2,
  parameter int SETTLE_CNT = 8
) (
  input  logic                eclk,
  input  logic                erst,
  input  logic                en,
  input  logic                clr_settle,
  input  logic [N*W-1:0]      i_in,
  output logic signed [W-1:0] v,
  output logic                logic_o,
  output logic                settled,
  output logic                sat_hi,
  output logic                sat_lo
);

  localparam int SW = W + $clog2(N) + 1;
  localparam int VW = SW + 1;
  localparam int CW = $clog2(SETTLE_CNT + 1);

  localparam logic signed [VW-1:0] VHI_X  = VW'(VHI);
  localparam logic signed [VW-1:0] VLO_X  = VW'(VLO);
  localparam logic signed [VW-1:0] EPS_X  = VW'(EPS);
  localparam logic signed [W-1:0]  INIT_W = W'(INIT);
  localparam logic signed [W-1:0]  THH_W  = W'(TH_HI);
  localparam logic signed [W-1:0]  THL_W  = W'(TH_LO);
  localparam logic [CW-1:0]        CMAX   = CW'(SETTLE_CNT);
  localparam logic                 LOGIC_INIT = (INIT > TH_HI);

  logic signed [W-1:0]  v_q, v_d;
  logic                 logic_q, logic_d;
  logic                 settled_q, settled_d;
  logic                 sat_hi_q, sat_hi_d;
  logic                 sat_lo_q, sat_lo_d;
  logic [CW-1:0]        cnt_q, cnt_d;

  logic signed [SW-1:0] sum;
  logic signed [SW-1:0] delta;
  logic signed [VW-1:0] nv;
  logic signed [VW-1:0] applied;
  logic                 quiet;

  always_comb begin
    sum = '0;
    for (int unsigned k = 0; k < N; k++) begin
      sum = sum + SW'($signed(i_in[k*W +: W]));
    end
    delta = sum >>> CAP_SHIFT;
  end

  always_comb begin
    v_d      = v_q;
    logic_d  = logic_q;
    sat_hi_d = sat_hi_q;
    sat_lo_d = sat_lo_q;
    nv       = VW'(v_q) + VW'(delta);
    if (en) begin
      sat_hi_d = 1'b0;
      sat_lo_d = 1'b0;
      if (nv > VHI_X) begin
        v_d      = W'(VHI_X);
        sat_hi_d = 1'b1;
      end else if (nv < VLO_X) begin
        v_d      = W'(VLO_X);
        sat_lo_d = 1'b1;
      end else begin
        v_d = W'(nv);
      end
      if (v_d > THH_W) begin
        logic_d = 1'b1;
      end else if (v_d < THL_W) begin
        logic_d = 1'b0;
      end
    end
  end

  // Quiet is judged on the post-clamp step, so a node pinned at a rail still settles.
  always_comb begin
    applied   = VW'(v_d) - VW'(v_q);
    quiet     = (applied <= EPS_X) && (applied >= -EPS_X);
    cnt_d     = cnt_q;
    if (clr_settle) begin
      cnt_d = '0;
    end else if (en) begin
      if (quiet) begin
        cnt_d = (cnt_q == CMAX) ? CMAX : cnt_q + CW'(1);
      end else begin
        cnt_d = '0;
      end
    end
    settled_d = (cnt_d == CMAX);
  end

  always_ff @(posedge eclk or posedge erst) begin
    if (erst) begin
      v_q       <= INIT_W;
      logic_q   <= LOGIC_INIT;
      settled_q <= 1'b0;
      sat_hi_q  <= 1'b0;
      sat_lo_q  <= 1'b0;
      cnt_q     <= '0;
    end else begin
      v_q       <= v_d;
      logic_q   <= logic_d;
      settled_q <= settled_d;
      sat_hi_q  <= sat_hi_d;
      sat_lo_q  <= sat_lo_d;
      cnt_q     <= cnt_d;
    end
  end

  assign v       = v_q;
  assign logic_o = logic_q;
  assign settled = settled_q;
  assign sat_hi  = sat_hi_q;
  assign sat_lo  = sat_lo_q;

endmodule

// File: tb/tb_node_integrator.sv
// Bench for node_integrator: directed scenarios plus random traffic, each compared
// against an integer-arithmetic model of the node.
module tb_node_integrator;
  localparam int W = 16;
  localparam int N = 4;

  logic                eclk = 1'b0;
  logic                erst = 1'b0;
  logic                en = 1'b0;
  logic                clr_settle = 1'b0;
  logic [N*W-1:0]      i_in = '0;
  logic signed [W-1:0] v;
  logic                logic_o, settled, sat_hi, sat_lo;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  int cur[N];
  int mv, mcnt;
  bit mlogic, msettled, msathi, msatlo;

  node_integrator #(.W(W), .N(N)) dut (
    .eclk(eclk), .erst(erst), .en(en), .clr_settle(clr_settle), .i_in(i_in),
    .v(v), .logic_o(logic_o), .settled(settled), .sat_hi(sat_hi), .sat_lo(sat_lo)
  );

  always #5 eclk = ~eclk;

  task automatic set_slots(input int a, input int b, input int c, input int d);
    cur[0] = a; cur[1] = b; cur[2] = c; cur[3] = d;
    for (int k = 0; k < N; k++) i_in[k*W +: W] = 16'(cur[k]);
  endtask

  task automatic model_reset();
    mv = -16384; mlogic = 0; mcnt = 0; msettled = 0; msathi = 0; msatlo = 0;
  endtask

  // floor(sum / 2) applied to the node, clamped to the rails
  task automatic model_step();
    int s, d, nv, newv;
    s = 0;
    for (int k = 0; k < N; k++) s += cur[k];
    d = s / 2;
    if (s < 0 && (s % 2) != 0) d -= 1;
    newv = mv;
    if (en) begin
      nv = mv + d;
      msathi = nv > 16384;
      msatlo = nv < -16384;
      newv = msathi ? 16384 : (msatlo ? -16384 : nv);
      if (newv > 4096) mlogic = 1;
      else if (newv < -4096) mlogic = 0;
    end
    if (clr_settle) mcnt = 0;
    else if (en) begin
      if ((newv - mv) <= 2 && (newv - mv) >= -2) mcnt = (mcnt < 8) ? mcnt + 1 : 8;
      else mcnt = 0;
    end
    msettled = (mcnt == 8);
    mv = newv;
  endtask

  task automatic cycle();
    @(posedge eclk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    erst = 1'b1;
    #2;
    model_reset();
    @(posedge eclk);
    #1;
    erst = 1'b0;
  endtask

  task automatic test_reset();
    en = 1'b1; clr_settle = 1'b0;
    set_slots(0, 0, 0, 0);
    do_reset();
    n_tests++;
    if (v !== -16'sd16384 || logic_o !== 1'b0 || settled !== 1'b0 || sat_hi !== 1'b0 || sat_lo !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: v=%0d logic=%b settled=%b sat=%b%b required v=-16384 0 0 00",
               v, logic_o, settled, sat_hi, sat_lo);
    end
    for (int k = 1; k <= 10; k++) begin
      cycle();
      n_tests++;
      if (v !== -16'sd16384 || settled !== (k >= 8) || sat_hi !== 1'b0 || sat_lo !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_settle[%0d]: v=%0d settled=%b sat=%b%b required v=-16384 settled=%b sat=00",
                 k, v, settled, sat_hi, sat_lo, k >= 8);
      end
    end
  endtask

  task automatic test_ramp();
    en = 1'b1;
    set_slots(4096, 0, 0, 0);
    do_reset();
    for (int k = 1; k <= 18; k++) begin
      cycle();
      n_tests++;
      if (v !== 16'(mv) || logic_o !== mlogic || sat_hi !== msathi || sat_lo !== msatlo) begin
        n_fail++;
        $display("FAIL ramp[%0d]: v=%0d logic=%b sat_hi=%b sat_lo=%b required %0d %b %b %b",
                 k, v, logic_o, sat_hi, sat_lo, mv, mlogic, msathi, msatlo);
      end
      if (k == 11) begin
        n_tests++;
        if (v !== 16'sd6144 || logic_o !== 1'b1) begin
          n_fail++;
          $display("FAIL ramp_logic_rise: v=%0d logic=%b required 6144 1", v, logic_o);
        end
      end
    end
  endtask

  task automatic test_hysteresis();
    en = 1'b1;
    set_slots(4096, 0, 0, 0);
    do_reset();
    repeat (11) cycle();
    set_slots(-4096, 0, 0, 0);
    for (int k = 1; k <= 6; k++) begin
      cycle();
      n_tests++;
      if (v !== 16'(6144 - 2048 * k) || logic_o !== (k < 6)) begin
        n_fail++;
        $display("FAIL hysteresis[%0d]: v=%0d logic=%b required %0d %b",
                 k, v, logic_o, 6144 - 2048 * k, k < 6);
      end
    end
  endtask

  task automatic test_opposing();
    en = 1'b1;
    set_slots(1000, -1000, 0, 0);
    repeat (8) cycle();
    n_tests++;
    if (settled !== 1'b1 || v !== 16'(mv)) begin
      n_fail++;
      $display("FAIL oppose_settle: settled=%b v=%0d required 1 %0d", settled, v, mv);
    end
    set_slots(1000, -1003, 0, 0);
    cycle();
    n_tests++;
    if (settled !== 1'b1 || v !== 16'(mv)) begin
      n_fail++;
      $display("FAIL oppose_quiet: settled=%b v=%0d required 1 %0d", settled, v, mv);
    end
    set_slots(1000, -1010, 0, 0);
    cycle();
    n_tests++;
    if (settled !== 1'b0 || v !== 16'(mv)) begin
      n_fail++;
      $display("FAIL oppose_loud: settled=%b v=%0d required 0 %0d", settled, v, mv);
    end
  endtask

  task automatic test_overflow();
    en = 1'b1;
    set_slots(4096, 0, 0, 0);
    do_reset();
    repeat (8) cycle();
    set_slots(-32768, -32768, -32768, -32768);
    cycle();
    n_tests++;
    if (v !== -16'sd16384 || sat_lo !== 1'b1 || sat_hi !== 1'b0) begin
      n_fail++;
      $display("FAIL overflow_clamp: v=%0d sat_lo=%b sat_hi=%b required -16384 1 0", v, sat_lo, sat_hi);
    end
    repeat (8) cycle();
    n_tests++;
    if (settled !== 1'b1 || v !== -16'sd16384) begin
      n_fail++;
      $display("FAIL rail_settle: settled=%b v=%0d required 1 -16384", settled, v);
    end
  endtask

  task automatic test_controls();
    logic signed [W-1:0] v0;
    logic l0, s0, h0, lo0;
    en = 1'b1;
    set_slots(3000, 0, 0, 0);
    repeat (3) cycle();
    set_slots(0, 0, 0, 0);
    repeat (8) cycle();
    v0 = v; l0 = logic_o; s0 = settled; h0 = sat_hi; lo0 = sat_lo;
    en = 1'b0;
    set_slots(5000, -200, 700, 1234);
    for (int k = 0; k < 5; k++) begin
      cycle();
      n_tests++;
      if (v !== v0 || logic_o !== l0 || settled !== s0 || sat_hi !== h0 || sat_lo !== lo0
          || v !== 16'(mv) || settled !== msettled) begin
        n_fail++;
        $display("FAIL en_hold[%0d]: v=%0d logic=%b settled=%b required %0d %b %b",
                 k, v, logic_o, settled, v0, l0, s0);
      end
    end
    clr_settle = 1'b1;
    cycle();
    clr_settle = 1'b0;
    n_tests++;
    if (settled !== 1'b0 || v !== v0) begin
      n_fail++;
      $display("FAIL clr_no_en: settled=%b v=%0d required 0 %0d", settled, v, v0);
    end
    en = 1'b1;
    cycle();
    #2;
    erst = 1'b1;
    #1;
    n_tests++;
    if (v !== -16'sd16384 || logic_o !== 1'b0 || sat_hi !== 1'b0 || sat_lo !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: v=%0d logic=%b sat=%b%b required -16384 0 00", v, logic_o, sat_hi, sat_lo);
    end
    model_reset();
    #1;
    erst = 1'b0;
    set_slots(100, 0, 0, 0);
    cycle();
    n_tests++;
    if (v !== -16'sd16334) begin
      n_fail++;
      $display("FAIL post_reset_update: v=%0d required -16334", v);
    end
  endtask

  task automatic test_random();
    int vals[N];
    for (int it = 0; it < 400; it++) begin
      for (int k = 0; k < N; k++) begin
        if ($urandom_range(9) == 0) vals[k] = int'($urandom_range(65535)) - 32768;
        else if ($urandom_range(3) == 0) vals[k] = int'($urandom_range(6)) - 3;
        else vals[k] = int'($urandom_range(4000)) - 2000;
      end
      set_slots(vals[0], vals[1], vals[2], vals[3]);
      en = ($urandom_range(4) != 0);
      clr_settle = ($urandom_range(15) == 0);
      cycle();
      n_tests++;
      if (v !== 16'(mv) || logic_o !== mlogic || settled !== msettled || sat_hi !== msathi || sat_lo !== msatlo) begin
        n_fail++;
        $display("FAIL random[%0d]: v=%0d logic=%b settled=%b sat=%b%b required %0d %b %b %b%b",
                 it, v, logic_o, settled, sat_hi, sat_lo, mv, mlogic, msettled, msathi, msatlo);
      end
      if ($urandom_range(7) == 0) begin
        set_slots(0, 0, 0, 0);
        en = 1'b1;
        clr_settle = 1'b0;
        repeat (9) cycle();
        n_tests++;
        if (settled !== msettled || v !== 16'(mv)) begin
          n_fail++;
          $display("FAIL random_quiet[%0d]: settled=%b v=%0d required %b %0d", it, settled, v, msettled, mv);
        end
      end
    end
    clr_settle = 1'b0;
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_hysteresis();
    test_opposing();
    test_overflow();
    test_controls();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
